// File: rtl/ring_phase_tracker.sv
// Lock/phase monitor for a 4-bit one-hot ring counter: acquires lock, reports phase, counts revolutions and faults.
// Optional all-zero (dead ring) detector enabled by defining RING_TRACK_DEAD_DET_EN.
module ring_phase_tracker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ring,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             fault,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             dead
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);

  logic [1:0] state, state_n;
  logic [3:0] hist;
  logic [3:0] good, good_n, good_inc;
  logic [3:0] rot_prev;
  logic       onehot, legal;
  logic       wrap_n, err_inc;

  assign rot_prev = {hist[2:0], hist[3]};
  assign onehot   = (ring != 4'b0000) && ((ring & (ring - 4'd1)) == 4'b0000);
  assign legal    = (ring == rot_prev);
  assign good_inc = good + 4'd1;

  function automatic logic [1:0] enc(input logic [3:0] r);
    case (r)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    good_n  = good;
    wrap_n  = 1'b0;
    err_inc = 1'b0;
    case (state)
      S_SEARCH: begin
        if (onehot) begin
          state_n = S_ACQ;
          good_n  = 4'd0;
        end
      end
      S_ACQ: begin
        if (legal) begin
          good_n = good_inc;
          if (good_inc == LOCK_LIM) state_n = S_LOCKED;
        end else if (onehot) begin
          good_n = 4'd0;
        end else begin
          state_n = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (legal) begin
          wrap_n = (hist == 4'b1000);
        end else begin
          state_n = S_FAULT;
          err_inc = 1'b1;
        end
      end
      default: begin
        if (clr) state_n = S_SEARCH;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they reflect the sample taken on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_SEARCH;
      hist    <= 4'b0000;
      good    <= 4'd0;
      phase   <= 2'd0;
      locked  <= 1'b0;
      fault   <= 1'b0;
      wrap    <= 1'b0;
      rev_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state  <= state_n;
      hist   <= ring;
      good   <= good_n;
      locked <= (state_n == S_LOCKED);
      fault  <= (state_n == S_FAULT);
      phase  <= (state_n == S_LOCKED) ? enc(ring) : 2'd0;
      wrap   <= wrap_n;
      if (wrap_n) rev_cnt <= rev_cnt + REV_W'(1);
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

`ifdef RING_TRACK_DEAD_DET_EN
  logic [7:0] dead_cnt, dead_inc;

  assign dead_inc = (dead_cnt == 8'hFF) ? dead_cnt : dead_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      dead_cnt <= 8'd0;
      dead     <= 1'b0;
    end else if (ring == 4'b0000) begin
      dead_cnt <= dead_inc;
      dead     <= (dead_inc >= 8'(DEAD_CYC));
    end else begin
      dead_cnt <= 8'd0;
      dead     <= 1'b0;
    end
  end
`else
  assign dead = 1'b0;
`endif

endmodule

// File: doc/ring_phase_tracker.md
# ring_phase_tracker

Downstream monitor for the 4-bit ring counter. It samples the ring's one-hot output every clock and acquires lock on a legal rotation sequence. Once locked it reports the binary phase index, counts revolutions and flags rotation faults. An optional detector also reports a dead (all-zero) ring. It sits between the ring counter and any logic that sequences on ring phase, and is the single point that qualifies the ring as trustworthy.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive legal rotations needed to declare lock; legal range 2..15.
- REV_W, 8: width of the revolution counter.
- ERR_W, 4: width of the saturating fault counter.
- DEAD_CYC, 8: consecutive all-zero samples before `dead` asserts; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ring  in  4  one-hot ring output; bit 0 is phase 0.
- clr  in  1  fault acknowledge; returns FAULT to SEARCH.
- phase  out  2  binary phase index; 0 unless locked.
- locked  out  1  ring is rotating legally.
- fault  out  1  a rotation fault was seen while locked; sticky until clr or rst.
- wrap  out  1  one-cycle pulse on each 1000 -> 0001 transition while locked.
- rev_cnt  out  REV_W  revolution count; wraps modulo 2^REV_W.
- err_cnt  out  ERR_W  count of faults entered; saturates at all-ones.
- dead  out  1  ring has been all-zero for at least DEAD_CYC samples.

## Operation
- Each edge k samples r_k = ring into a history register. Checks compare r_k against rot(r_{k-1}) = {r_{k-1}[2:0], r_{k-1}[3]}.
- One-hot means exactly one bit set. Encoding: 0001->0, 0010->1, 0100->2, 1000->3.
- FSM states: SEARCH, ACQ, LOCKED, FAULT.
  - SEARCH: a one-hot r_k moves to ACQ with the good-count set to 0. Otherwise stay in SEARCH.
  - ACQ: if r_k == rot(r_{k-1}), good-count increments; when it reaches LOCK_CNT, move to LOCKED. If r_k is one-hot but not the rotation, stay in ACQ and reset good-count to 0. If r_k is not one-hot, move to SEARCH.
  - LOCKED: r_k == rot(r_{k-1}) stays in LOCKED. Any mismatch moves to FAULT and increments err_cnt (saturating).
  - FAULT: holds until clr=1, then moves to SEARCH. Ring activity is ignored in FAULT.
- Outputs by state:
  - locked=1 only in LOCKED.
  - fault=1 only in FAULT.
  - phase = enc(r_k) in LOCKED, else 0.
- wrap=1 for one cycle when in LOCKED and the transition 1000 -> 0001 is seen. On the same edge rev_cnt increments.
- rev_cnt and err_cnt are cleared only by rst; clr does not touch them.
- Counter widths: rev_cnt wraps from 2^REV_W-1 to 0. err_cnt holds at 2^ERR_W-1 once reached.

## Timing
- Every output is registered. An output updated at edge k reflects sample r_k, so latency is 1 cycle from ring to outputs.
- Lock latency: if the first one-hot sample is at edge k and every following sample is a legal rotation, locked=1 after edge k+LOCK_CNT.
- Fault: the mismatching edge in LOCKED gives locked=0, fault=1, phase=0 and err_cnt+1, all on that same edge.
- clr in FAULT: fault=0 at that edge, state becomes SEARCH. The next edge may enter ACQ. clr in any other state has no effect.
- rst (also mid-operation) wins over everything. At the next edge: state=SEARCH, history=0000, phase=0, locked=0, fault=0, wrap=0, rev_cnt=0, err_cnt=0, dead=0, dead counter=0.
- rst and clr asserted together: reset behaviour applies.

## Configuration
- Macro: RING_TRACK_DEAD_DET_EN.
- With the macro defined:
  - An 8-bit saturating dead counter increments on each all-zero sample and clears on any nonzero sample.
  - dead=1 from the edge at which the count reaches DEAD_CYC.
  - dead drops at the first edge with a nonzero sample.
  - Detection runs independently of FSM state.
- Without the macro: dead is tied to 0 and no dead counter is instantiated. FSM behaviour is unchanged.

## Test plan
- Lock and phase: after rst, drive 0001, 0010, 0100, 1000 repeating (LOCK_CNT=4).
  - Required: locked=1 after the 5th edge; phase follows 0, 1, 2, 3; wrap pulses on each 1000->0001; rev_cnt increments once per revolution.
- Fault and acknowledge: while locked, inject 0101.
  - Required: on that edge fault=1, locked=0, phase=0, err_cnt=1.
  - Then hold 0010 with clr=0 for 3 cycles: fault stays 1.
  - Then pulse clr: fault=0 and state is SEARCH.
- Acquisition rejection: drive 0001, 0100.
  - Required: stays in ACQ with good-count reset.
  - Then drive 0000: returns to SEARCH; locked never asserts.
- Dead detect (macro on, DEAD_CYC=8): hold ring=0000.
  - Required: dead=1 after the 8th edge; then drive 0001 and dead=0 at that edge.
  - With the macro off, dead stays 0 throughout.
- Saturation and wrap: force 20 fault/clr cycles (ERR_W=4) and 256 locked revolutions (REV_W=8).
  - Required: err_cnt holds at 15; rev_cnt returns to 0.
- Reset mid-lock: assert rst for 1 cycle while locked with rev_cnt=5.
  - Required: all outputs 0 at the next edge; relock needs LOCK_CNT fresh legal rotations.
